// File: rtl/shift_unit_if.sv
// Operand/control and status bundle for shift_unit.
// The control FSM drives the master side; the shifter is the slave.
interface shift_unit_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2*IN_W-1,
  parameter int CNT_W = $clog2(OUT_W+1)
);
  logic [IN_W-1:0]  in;
  logic             load;
  logic             sign_ext;
  logic [1:0]       mode;
  logic [CNT_W-1:0] n_shifts;
  logic             en;
  logic [OUT_W-1:0] out;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             shift_out;

  modport master (
    output in, load, sign_ext, mode, n_shifts, en,
    input  out, count, busy, done, shift_out
  );

  modport slave (
    input  in, load, sign_ext, mode, n_shifts, en,
    output out, count, busy, done, shift_out
  );
endinterface

// File: rtl/shift_unit.sv
// Multi-mode shift register for the sequential multiplier: loads an operand,
// then performs a programmed number of 1-bit shifts and pulses done.
module shift_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2*IN_W-1,
  parameter int CNT_W = $clog2(OUT_W+1)
) (
  input logic         clk,
  input logic         rst_n,
  shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [CNT_W-1:0] MAX_SHIFTS = CNT_W'(OUT_W);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             done_q, done_d;
  logic             shift_out_q, shift_out_d;

  logic [OUT_W-1:0] in_ext;
  logic [CNT_W-1:0] target_sat;

  // Sign or zero extension of the operand, valid for OUT_W == IN_W too.
  always_comb begin
    for (int i = 0; i < OUT_W; i++) begin
      if (i < IN_W) in_ext[i] = bus.in[i];
      else          in_ext[i] = bus.sign_ext & bus.in[IN_W-1];
    end
  end

  assign target_sat = (bus.n_shifts > MAX_SHIFTS) ? MAX_SHIFTS : bus.n_shifts;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    out_d       = out_q;
    count_d     = count_q;
    target_d    = target_q;
    shift_out_d = shift_out_q;
    done_d      = 1'b0;

    if (bus.load) begin
      // Load wins in either state; an in-flight job is silently abandoned.
      out_d       = in_ext;
      count_d     = '0;
      mode_d      = mode_e'(bus.mode);
      target_d    = target_sat;
      shift_out_d = 1'b0;
      if (target_sat == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = SHIFT;
      end
    end else begin
      case (state_q)
        IDLE: ;
        SHIFT: begin
          if (bus.en) begin
            case (mode_q)
              MODE_LSL: begin
                out_d       = {out_q[OUT_W-2:0], 1'b0};
                shift_out_d = out_q[OUT_W-1];
              end
              MODE_LSR: begin
                out_d       = {1'b0, out_q[OUT_W-1:1]};
                shift_out_d = out_q[0];
              end
              MODE_ASR: begin
                out_d       = {out_q[OUT_W-1], out_q[OUT_W-1:1]};
                shift_out_d = out_q[0];
              end
              MODE_ROL: begin
                out_d       = {out_q[OUT_W-2:0], out_q[OUT_W-1]};
                shift_out_d = out_q[OUT_W-1];
              end
              default: ;
            endcase
            count_d = count_q + CNT_W'(1);
            if (count_d == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= MODE_LSL;
      out_q       <= '0;
      count_q     <= '0;
      target_q    <= '0;
      done_q      <= 1'b0;
      shift_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      count_q     <= count_d;
      target_q    <= target_d;
      done_q      <= done_d;
      shift_out_q <= shift_out_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.count     = count_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = done_q;
  assign bus.shift_out = shift_out_q;

endmodule
